// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port round-robin arbiter in front of a single-port
// synchronous RAM with a shared bidirectional data bus.
// Optional feature: define ARB_ADDR_CHECK_EN to reject granted addresses
// >= addrLimit with a 1-cycle error acknowledge (no RAM access).
//
// Handshake: a requester raises reqN with weN/addrN/wdataN stable and holds
// it until ackN pulses for one cycle; rdataN/errN are valid in that cycle.
// The request is latched at grant, so dropping reqN early does not abort it.
module ram_arbiter #(
    parameter int          dataWidth = 64,
    parameter logic [31:0] addrLimit = 32'hFFF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req0,
    input  logic                 req1,
    input  logic                 we0,
    input  logic                 we1,
    input  logic [31:0]          addr0,
    input  logic [31:0]          addr1,
    input  logic [dataWidth-1:0] wdata0,
    input  logic [dataWidth-1:0] wdata1,
    output logic                 ack0,
    output logic                 ack1,
    output logic [dataWidth-1:0] rdata0,
    output logic [dataWidth-1:0] rdata1,
    output logic                 err0,
    output logic                 err1,
    output logic [31:0]          ram_address,
    inout  wire  [dataWidth-1:0] ram_data,
    output logic                 ram_select,
    output logic                 ram_write,
    output logic                 ram_out,
    output logic [2:0]           fsm_state
);

`ifdef ARB_ADDR_CHECK_EN
    localparam bit addr_check_en = 1'b1;
`else
    localparam bit addr_check_en = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ1 = 3'd2,
        READ2 = 3'd3,
        ACK   = 3'd4
    } state_t;

    state_t                 state;
    logic                   last_grant;   // port granted most recently
    logic                   grant_q;      // port owning the current transaction
    logic                   drive_en;     // bus driven only during WRITE
    logic [dataWidth-1:0]   wdata_q;

    logic                   grant_sel;
    logic                   sel_we;
    logic [31:0]            sel_addr;
    logic [dataWidth-1:0]   sel_wdata;
    logic                   sel_oob;

    assign ram_data  = drive_en ? wdata_q : {dataWidth{1'bz}};
    assign fsm_state = state;

    // Round-robin pick and mux of the winning port's request fields
    always_comb begin
        grant_sel = 1'b0;
        if (req0 && req1) begin
            grant_sel = ~last_grant;
        end else if (req1) begin
            grant_sel = 1'b1;
        end
        sel_we    = grant_sel ? we1    : we0;
        sel_addr  = grant_sel ? addr1  : addr0;
        sel_wdata = grant_sel ? wdata1 : wdata0;
        sel_oob   = addr_check_en && (sel_addr >= addrLimit);
    end

    // Transaction FSM with all outputs registered
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            grant_q     <= 1'b0;
            drive_en    <= 1'b0;
            wdata_q     <= '0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            err0        <= 1'b0;
            err1        <= 1'b0;
            rdata0      <= '0;
            rdata1      <= '0;
            ram_address <= '0;
            ram_select  <= 1'b0;
            ram_write   <= 1'b0;
            ram_out     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        grant_q     <= grant_sel;
                        last_grant  <= grant_sel;
                        ram_address <= sel_addr;
                        wdata_q     <= sel_wdata;
                        if (sel_oob) begin
                            state <= ACK;
                            ack0  <= ~grant_sel;
                            ack1  <= grant_sel;
                            err0  <= ~grant_sel;
                            err1  <= grant_sel;
                        end else if (sel_we) begin
                            state      <= WRITE;
                            ram_select <= 1'b1;
                            ram_write  <= 1'b1;
                            drive_en   <= 1'b1;
                        end else begin
                            state      <= READ1;
                            ram_select <= 1'b1;
                            ram_out    <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    state      <= ACK;
                    ram_select <= 1'b0;
                    ram_write  <= 1'b0;
                    drive_en   <= 1'b0;
                    ack0       <= ~grant_q;
                    ack1       <= grant_q;
                end
                READ1: begin
                    // RAM registers its output on this edge
                    state <= READ2;
                end
                READ2: begin
                    state      <= ACK;
                    ram_select <= 1'b0;
                    ram_out    <= 1'b0;
                    ack0       <= ~grant_q;
                    ack1       <= grant_q;
                    if (grant_q) begin
                        rdata1 <= ram_data;
                    end else begin
                        rdata0 <= ram_data;
                    end
                end
                ACK: begin
                    state       <= IDLE;
                    ack0        <= 1'b0;
                    ack1        <= 1'b0;
                    err0        <= 1'b0;
                    err1        <= 1'b0;
                    ram_address <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
